// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - single-entry decode/issue controller with RAW countdown scoreboard
//
// Holds one decoded RV32I instruction, works out which source registers it reads
// and whether it writes rd, and offers it to execute only once no source has a
// pending write. Pending writes live in 31 2-bit countdown counters (x1..x31).
//
// Parameters:
//   LOAD_LAT  cycles after issue before a LOAD result can be consumed (1..3)
//   ALU_LAT   same for every other rd-writing instruction (0..3, 0 = untracked)
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid / in_ready         upstream handshake for a decoded instruction
//   in_opcode, in_funct3,
//   in_rd, in_rs1, in_rs2       decoded fields
//   flush                       drop the held instruction (redirect)
//   issue_valid / issue_ready   execute handshake
//   issue_opcode, issue_funct3,
//   issue_rd, issue_rs1,
//   issue_rs2                   held fields
//   stall                       entry held but blocked by a hazard
//   stall_count                 cycles spent stalled (only with ISSUE_CTRL_PERF_EN)
//
// Build option: define ISSUE_CTRL_PERF_EN to add the stall_count performance counter.

module issue_ctrl #(
    parameter int LOAD_LAT = 2,
    parameter int ALU_LAT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic        flush,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [6:0]  issue_opcode,
    output logic [2:0]  issue_funct3,
    output logic [4:0]  issue_rd,
    output logic [4:0]  issue_rs1,
    output logic [4:0]  issue_rs2,
    output logic        stall
`ifdef ISSUE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_CSR    = 7'b1110011;

    localparam logic [1:0] LOAD_LAT_W = LOAD_LAT[1:0];
    localparam logic [1:0] ALU_LAT_W  = ALU_LAT[1:0];

    logic        held_v_q, held_v_d;
    logic [6:0]  op_q, op_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [1:0]  cnt_q [0:31];
    logic [1:0]  cnt_d [0:31];

    logic        use_rs1, use_rs2, writes_rd, is_load;
    logic        hazard, in_fire, issue_fire;
    logic [1:0]  lat, dec;

    // Classification of the held instruction.
    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (op_q)
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            OP_JALR, OP_ITYPE: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
            end
            OP_LOAD: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_RTYPE: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            // funct3[2] set selects the immediate CSR forms: rs1 field is a zimm.
            OP_CSR: begin
                use_rs1   = ~f3_q[2];
                writes_rd = 1'b1;
            end
            default: ;
        endcase
        if (rd_q == 5'd0) begin
            writes_rd = 1'b0;
        end
    end

    // cnt_q[0] is held at zero, so x0 sources never raise a hazard.
    assign hazard      = (use_rs1 && (cnt_q[rs1_q] != 2'd0)) ||
                         (use_rs2 && (cnt_q[rs2_q] != 2'd0));
    assign issue_valid = held_v_q & ~hazard;
    assign stall       = held_v_q & hazard;
    assign issue_fire  = issue_valid & issue_ready;
    assign in_ready    = ~held_v_q | issue_fire;
    assign in_fire     = in_valid & in_ready;
    assign lat         = is_load ? LOAD_LAT_W : ALU_LAT_W;

    // Entry next state; flush wins over a same-cycle capture.
    always_comb begin
        held_v_d = held_v_q;
        op_d     = op_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        if (flush) begin
            held_v_d = 1'b0;
        end else if (in_fire) begin
            held_v_d = 1'b1;
            op_d     = in_opcode;
            f3_d     = in_funct3;
            rd_d     = in_rd;
            rs1_d    = in_rs1;
            rs2_d    = in_rs2;
        end else if (issue_fire) begin
            held_v_d = 1'b0;
        end
    end

    // Scoreboard next state: everything counts down; an issuing writer raises
    // its rd counter to at least its latency. Hazard above uses cnt_q, so an
    // instruction reading its own rd is judged before its write is recorded.
    always_comb begin
        dec      = 2'd0;
        cnt_d[0] = 2'd0;
        for (int i = 1; i < 32; i++) begin
            dec      = (cnt_q[i] != 2'd0) ? cnt_q[i] - 2'd1 : 2'd0;
            cnt_d[i] = dec;
            if (issue_fire && writes_rd && (rd_q == 5'(i))) begin
                cnt_d[i] = (dec > lat) ? dec : lat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_v_q <= 1'b0;
            op_q     <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
        end else begin
            held_v_q <= held_v_d;
            op_q     <= op_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign issue_opcode = op_q;
    assign issue_funct3 = f3_q;
    assign issue_rd     = rd_q;
    assign issue_rs1    = rs1_q;
    assign issue_rs2    = rs2_q;

`ifdef ISSUE_CTRL_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;

    assign stall_count_d = stall ? stall_count_q + 32'd1 : stall_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - scoreboard bench for issue_ctrl with directed vectors

module tb_issue_ctrl;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_CSR   = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic        flush;
    logic        issue_valid, issue_ready;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        stall;
`ifdef ISSUE_CTRL_PERF_EN
    logic [31:0] stall_count;
    logic [31:0] sc_before;
`endif

    issue_ctrl #(.LOAD_LAT(2), .ALU_LAT(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_funct3    (in_funct3),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_opcode (issue_opcode),
        .issue_funct3 (issue_funct3),
        .issue_rd     (issue_rd),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .stall        (stall)
`ifdef ISSUE_CTRL_PERF_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] fields;
        int          when;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every issue handshake must match the oldest expected record,
    // both in content and in the cycle it happens.
    always @(negedge clk) begin
        if (issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_issue: op %0h rd %0d (cycle %0d)", issue_opcode, issue_rd, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("issue_fields", {issue_opcode, issue_funct3, issue_rd, issue_rs1, issue_rs2}, 32'(e.fields));
                chk("issue_cycle", 32'(cyc), 32'(e.when));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
        in_valid  = 1'b1;
        in_opcode = op;
        in_funct3 = f3;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
    endtask

    task automatic none();
        in_valid = 1'b0;
    endtask

    task automatic expect_issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input int when);
        exp_t e;
        e.fields = {op, f3, rd, rs1, rs2};
        e.when   = when;
        exp_q.push_back(e);
    endtask

    task automatic gap();
        none();
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1; flush = 1'b0; issue_ready = 1'b1;
        in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        repeat (2) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fields", {7'd0, issue_opcode, issue_funct3, issue_rd, issue_rs1, issue_rs2}, 32'd0);
`ifdef ISSUE_CTRL_PERF_EN
        chk("rst_stall_count", stall_count, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // ADDI x1,x0,5: issues the cycle after capture.
        c = cyc;
        put(OP_ITYPE, 3'b000, 5'd1, 5'd0, 5'd5); expect_issue(OP_ITYPE, 3'b000, 5'd1, 5'd0, 5'd5, c + 1);
        tick(); none();
        gap();

        // LOAD x5 then ADD x6,x5,x7: two stall cycles.
        c = cyc;
        put(OP_LOAD, 3'b010, 5'd5, 5'd2, 5'd0); expect_issue(OP_LOAD, 3'b010, 5'd5, 5'd2, 5'd0, c + 1);
        tick();
        put(OP_RTYPE, 3'b000, 5'd6, 5'd5, 5'd7); expect_issue(OP_RTYPE, 3'b000, 5'd6, 5'd5, 5'd7, c + 4);
`ifdef ISSUE_CTRL_PERF_EN
        @(negedge clk); sc_before = stall_count;
`endif
        tick(); none();
        @(negedge clk); chk("lu_stall_1", 32'(stall), 32'd1); chk("lu_in_ready", 32'(in_ready), 32'd0);
        tick();
        @(negedge clk); chk("lu_stall_2", 32'(stall), 32'd1);
        tick();
        @(negedge clk); chk("lu_stall_3", 32'(stall), 32'd0); chk("lu_issue", 32'(issue_valid), 32'd1);
`ifdef ISSUE_CTRL_PERF_EN
        chk("perf_stall_count", stall_count - sc_before, 32'd2);
`endif
        gap();

        // ALU_LAT=0: ADDI x5 then ADD x6,x5,x5 without stall.
        c = cyc;
        put(OP_ITYPE, 3'b000, 5'd5, 5'd0, 5'd3); expect_issue(OP_ITYPE, 3'b000, 5'd5, 5'd0, 5'd3, c + 1);
        tick();
        put(OP_RTYPE, 3'b000, 5'd6, 5'd5, 5'd5); expect_issue(OP_RTYPE, 3'b000, 5'd6, 5'd5, 5'd5, c + 2);
        tick(); none();
        @(negedge clk); chk("alu_fwd_stall", 32'(stall), 32'd0);
        gap();

        // LOAD x0 then ADD x1,x0,x0: x0 is never tracked.
        c = cyc;
        put(OP_LOAD, 3'b010, 5'd0, 5'd0, 5'd0); expect_issue(OP_LOAD, 3'b010, 5'd0, 5'd0, 5'd0, c + 1);
        tick();
        put(OP_RTYPE, 3'b000, 5'd1, 5'd0, 5'd0); expect_issue(OP_RTYPE, 3'b000, 5'd1, 5'd0, 5'd0, c + 2);
        tick(); none();
        @(negedge clk); chk("x0_stall", 32'(stall), 32'd0);
        gap();

        // CSRRWI ignores its rs1 field; CSRRW does not.
        c = cyc;
        put(OP_LOAD, 3'b010, 5'd5, 5'd0, 5'd0); expect_issue(OP_LOAD, 3'b010, 5'd5, 5'd0, 5'd0, c + 1);
        tick();
        put(OP_CSR, 3'b101, 5'd0, 5'd5, 5'd0); expect_issue(OP_CSR, 3'b101, 5'd0, 5'd5, 5'd0, c + 2);
        tick();
        put(OP_CSR, 3'b001, 5'd0, 5'd5, 5'd0); expect_issue(OP_CSR, 3'b001, 5'd0, 5'd5, 5'd0, c + 4);
        @(negedge clk); chk("csrrwi_stall", 32'(stall), 32'd0);
        tick(); none();
        @(negedge clk); chk("csrrw_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk); chk("csrrw_issue", 32'(issue_valid), 32'd1);
        gap();

        // Flush a stalled entry, then flush against an incoming instruction into an empty entry.
        c = cyc;
        put(OP_LOAD, 3'b010, 5'd5, 5'd0, 5'd0); expect_issue(OP_LOAD, 3'b010, 5'd5, 5'd0, 5'd0, c + 1);
        tick();
        put(OP_RTYPE, 3'b000, 5'd6, 5'd5, 5'd0);
        tick();
        flush = 1'b1;
        put(OP_ITYPE, 3'b000, 5'd9, 5'd0, 5'd0);
        @(negedge clk); chk("flush_pre_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk); chk("flush_dropped", 32'(issue_valid | stall), 32'd0); chk("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        flush = 1'b0;
        put(OP_RTYPE, 3'b000, 5'd6, 5'd5, 5'd0); expect_issue(OP_RTYPE, 3'b000, 5'd6, 5'd5, 5'd0, c + 5);
        @(negedge clk); chk("flush_incoming_dropped", 32'(issue_valid), 32'd0);
        tick(); none();
        gap();

        // Execute back-pressure for 3 cycles; the next instruction waits behind it.
        c = cyc;
        put(OP_ITYPE, 3'b000, 5'd7, 5'd0, 5'd1); expect_issue(OP_ITYPE, 3'b000, 5'd7, 5'd0, 5'd1, c + 4);
        tick();
        issue_ready = 1'b0;
        put(OP_ITYPE, 3'b000, 5'd8, 5'd0, 5'd2); expect_issue(OP_ITYPE, 3'b000, 5'd8, 5'd0, 5'd2, c + 5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_issue_valid", 32'(issue_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_fields", {7'd0, issue_opcode, issue_funct3, issue_rd, issue_rs1, issue_rs2},
                {7'd0, OP_ITYPE, 3'b000, 5'd7, 5'd0, 5'd1});
            tick();
        end
        issue_ready = 1'b1;
        tick(); none();
        gap();

        // LOAD x3,0(x3) twice: first is free of its own write, second waits for it.
        c = cyc;
        put(OP_LOAD, 3'b010, 5'd3, 5'd3, 5'd0); expect_issue(OP_LOAD, 3'b010, 5'd3, 5'd3, 5'd0, c + 1);
        tick();
        expect_issue(OP_LOAD, 3'b010, 5'd3, 5'd3, 5'd0, c + 4);
        tick(); none();
        @(negedge clk); chk("selfdep_stall", 32'(stall), 32'd1);
        tick(); tick();
        gap();

        // Reset in the middle of a stall clears entry and scoreboard.
        c = cyc;
        put(OP_LOAD, 3'b010, 5'd5, 5'd0, 5'd0); expect_issue(OP_LOAD, 3'b010, 5'd5, 5'd0, 5'd0, c + 1);
        tick();
        put(OP_RTYPE, 3'b000, 5'd6, 5'd5, 5'd0);
        tick(); none();
        @(negedge clk); chk("rst_mid_stall_pre", 32'(stall), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        put(OP_RTYPE, 3'b000, 5'd6, 5'd5, 5'd0); expect_issue(OP_RTYPE, 3'b000, 5'd6, 5'd5, 5'd0, cyc + 1);
        tick(); none();
        gap();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Single-entry decode/issue controller between instruction fetch and execute in the RV32I pipeline. It captures one decoded instruction, classifies register use from opcode/funct3, and tracks pending register writes in a per-register countdown scoreboard. It holds the instruction on a read-after-write hazard and issues it once every source is available, so load-use and multi-cycle results stall correctly.

## Interface
- `LOAD_LAT`, default 2: cycles after issue before a LOAD's rd can be consumed (1..3).
- `ALU_LAT`, default 0: same, for all other rd-writing instructions (0..3; 0 = full forwarding, no tracking).
- `clk` input 1: clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: upstream has a decoded instruction.
- `in_ready` output 1: entry free or draining this cycle.
- `in_opcode` input 7, `in_funct3` input 3, `in_rd`/`in_rs1`/`in_rs2` input 5 each: decoded fields.
- `flush` input 1: discard the held instruction (branch/jump redirect).
- `issue_valid` output 1: held instruction is hazard-free and offered to execute.
- `issue_ready` input 1: execute accepts.
- `issue_opcode` output 7, `issue_funct3` output 3, `issue_rd`/`issue_rs1`/`issue_rs2` output 5 each: held fields.
- `stall` output 1: entry valid but blocked by a hazard.

## Operation
- Input fire: `in_valid & in_ready`. Issue fire: `issue_valid & issue_ready`.
- `in_ready = !held_v | issue_fire`; a new instruction loads the entry in the issue-fire cycle (back-to-back throughput 1/cycle).
- Source use: LUI, AUIPC, JAL none; JALR, LOAD, ARI_ITYPE rs1; BRANCH, STORE, ARI_RTYPE rs1+rs2; CSR rs1 only when `funct3[2]==0`; any other opcode none.
- Writes rd: LUI, AUIPC, JAL, JALR, LOAD, ARI_ITYPE, ARI_RTYPE, CSR; never when rd==0. BRANCH/STORE never write.
- Scoreboard: 31 2-bit counters (x1..x31; x0 is constant 0). Each cycle every non-zero counter decrements by 1.
- On issue fire with a tracked write: `cnt[rd] <= max(cnt[rd]-1 saturating at 0, LAT)`, with LAT = LOAD_LAT for LOAD and ALU_LAT otherwise.
- Hazard: any used source with `cnt != 0`. `issue_valid = held_v & !hazard`; `stall = held_v & hazard`.
- Flush: `held_v <= 0` next edge, taking priority over input fire in the same cycle (a same-cycle incoming instruction is dropped). Scoreboard is untouched: in-flight writes still complete.
- Unknown opcode: issued with no sources and no write.

## Timing
- Reset: `held_v=0`, all counters 0, `in_ready=1`, `issue_valid=0`, `stall=0`, held fields 0, perf counter 0.
- Entry and scoreboard are registered; `issue_valid`, `stall`, `in_ready` are combinational from registered state plus `issue_ready`. No combinational path from `in_*` to `issue_*`.
- Input fire at edge N → earliest `issue_valid` in cycle N+1.
- LOAD to x5 issued at edge N, LOAD_LAT=2 → dependent instruction stalls in cycles N+1 and N+2 and issues in cycle N+3.
- Issued instruction may depend on itself (`rs1==rd`): hazard is evaluated before the write is recorded.
- `issue_valid` must not drop without a fire unless `flush` or a hazard appears (execute is free to hold `issue_ready` low).
- Reset mid-stall: entry and scoreboard cleared immediately.

## Configuration
- `ISSUE_CTRL_PERF_EN` defined: adds output `stall_count` (32-bit), incremented every cycle `stall==1`, wrapping at 2^32, cleared by `rst`.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset → `in_ready=1`, `issue_valid=0`, all counters 0; ADDI x1,x0,5 accepted then issues the next cycle with `issue_rd=1`.
- LOAD x5 then ADD x6,x5,x7 back-to-back with LOAD_LAT=2 → ADD has `stall=1` for 2 cycles and issues on the 3rd; with ALU_LAT=0, ADDI x5 then ADD x6,x5,x5 → no stall.
- Writes to x0 (LOAD x0) then ADD x1,x0,x0 → no stall.
- CSRRWI with `funct3=3'b101`, rs1 field=5 while x5 busy → no stall; CSRRW (`funct3=3'b001`) → stalls.
- `flush` asserted while a stalled entry is held, together with `in_valid` → entry dropped, incoming instruction not captured, `issue_valid=0` next cycle; scoreboard keeps counting down.
- `issue_ready=0` for 3 cycles with a valid entry → `issue_valid` stays 1, fields stable, `in_ready=0`; with `ISSUE_CTRL_PERF_EN`, a 2-cycle load-use stall yields `stall_count=2`.
